// File: rtl/char_pattern_gen.sv
// Packetised two-operand toggle-pattern generator for datapath energy characterization.
// A flit is presented the cycle after start or GAP exit, and P stalls while ready is low.
module char_pattern_gen #(
  parameter int          N       = 23,
  parameter int          PAYLOAD = 20,
  parameter int          GAP     = 7,
  parameter logic [31:0] SEED    = 32'h0000_0001
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    mode,
  input  logic [15:0]   num_pkt,
  input  logic          ready,
  output logic          valid,
  output logic [N-1:0]  input1,
  output logic [N-1:0]  input2,
  output logic          busy,
  output logic          meas_win,
  output logic          done,
  output logic [15:0]   pkt_cnt
);

  localparam int          W        = 2 * N;
  localparam int          FW       = $clog2(PAYLOAD + 1);
  localparam int          GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [31:0] MASK     = 32'h8020_0003;
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state;
  logic [1:0]    mode_q;
  logic [15:0]   num_q;
  logic [W-1:0]  p;
  logic [31:0]   l;
  logic [FW-1:0] flit_cnt;
  logic [GW-1:0] gap_cnt;

  logic [31:0]   l_step;
  logic [31:0]   l_init;
  logic [W-1:0]  p_step;
  logic [W-1:0]  p_init;
  logic [1:0]    init_mode;
  logic          last_flit;
  logic          run_end;
  logic [15:0]   pkt_inc;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? MASK : 32'h0);
  endfunction

  function automatic logic [W-1:0] pat_step(input logic [1:0] m, input logic [W-1:0] cur,
                                            input logic [31:0] lnew);
    logic [W-1:0] r;
    r = '0;
    case (m)
      2'd1:    r = {cur[W-2:0], ~cur[W-1]};
      2'd2:    for (int i = 0; i < W; i++) r[i] = lnew[i % 32];
      2'd3:    r = ~cur;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Packet start re-seeds from a zero pattern; in IDLE the not-yet-latched mode applies.
  assign init_mode = (state == S_IDLE) ? mode : mode_q;
  assign l_step    = lfsr_step(l);
  assign l_init    = lfsr_step(SEED_EFF);
  assign p_step    = pat_step(mode_q, p, l_step);
  assign p_init    = pat_step(init_mode, '0, l_init);

  assign last_flit = (flit_cnt == FW'(PAYLOAD - 1));
  assign run_end   = ({1'b0, pkt_cnt} + 17'd1) == {1'b0, num_q};
  assign pkt_inc   = (pkt_cnt == 16'hFFFF) ? pkt_cnt : pkt_cnt + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      mode_q   <= 2'd0;
      num_q    <= 16'd0;
      p        <= '0;
      l        <= SEED_EFF;
      flit_cnt <= '0;
      gap_cnt  <= '0;
      pkt_cnt  <= 16'd0;
      meas_win <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            mode_q   <= mode;
            num_q    <= num_pkt;
            pkt_cnt  <= 16'd0;
            flit_cnt <= '0;
            gap_cnt  <= '0;
            if (num_pkt == 16'd0) begin
              state <= S_DONE;
            end else begin
              state    <= S_SEND;
              p        <= p_init;
              l        <= l_init;
              meas_win <= 1'b1;
            end
          end
        end
        S_SEND: begin
          if (abort) begin
            state    <= S_IDLE;
            meas_win <= 1'b0;
          end else if (ready) begin
            if (!last_flit) begin
              p        <= p_step;
              l        <= l_step;
              flit_cnt <= flit_cnt + FW'(1);
            end else begin
              flit_cnt <= '0;
              pkt_cnt  <= pkt_inc;
              if (run_end) begin
                state    <= S_DONE;
                meas_win <= 1'b0;
              end else if (GAP > 0) begin
                state   <= S_GAP;
                gap_cnt <= '0;
              end else begin
                p <= p_init;
                l <= l_init;
              end
            end
          end
        end
        S_GAP: begin
          if (abort) begin
            state    <= S_IDLE;
            meas_win <= 1'b0;
          end else if (gap_cnt == GW'(GAP - 1)) begin
            state   <= S_SEND;
            gap_cnt <= '0;
            p       <= p_init;
            l       <= l_init;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign valid  = (state == S_SEND);
  assign busy   = (state == S_SEND) || (state == S_GAP);
  assign done   = (state == S_DONE);
  assign input1 = p[N-1:0];
  assign input2 = p[W-1:N];

endmodule

// File: tb/tb_char_pattern_gen.sv
// Directed bench for char_pattern_gen: N=4, PAYLOAD=3, GAP=2 and a GAP=0 twin.
module tb_char_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start0, abort, ready;
  logic [1:0]  mode;
  logic [15:0] num_pkt;

  logic        valid, busy, meas_win, done;
  logic [3:0]  input1, input2;
  logic [15:0] pkt_cnt;

  logic        valid0, busy0, meas_win0, done0;
  logic [3:0]  input1_0, input2_0;
  logic [15:0] pkt_cnt0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  char_pattern_gen #(.N(4), .PAYLOAD(3), .GAP(2), .SEED(32'h1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .num_pkt(num_pkt), .ready(ready), .valid(valid), .input1(input1),
    .input2(input2), .busy(busy), .meas_win(meas_win), .done(done),
    .pkt_cnt(pkt_cnt)
  );

  char_pattern_gen #(.N(4), .PAYLOAD(3), .GAP(0), .SEED(32'h1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort), .mode(mode),
    .num_pkt(num_pkt), .ready(ready), .valid(valid0), .input1(input1_0),
    .input2(input2_0), .busy(busy0), .meas_win(meas_win0), .done(done0),
    .pkt_cnt(pkt_cnt0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Start pulse driven between two falling edges; returns with the first flit visible.
  task automatic kick(input logic [1:0] m, input logic [15:0] n);
    mode    = m;
    num_pkt = n;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start0 = 1'b0; abort = 1'b0; ready = 1'b1;
    mode = 2'd0; num_pkt = 16'd0;
    tick();
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_pat", {24'd0, input2, input1}, 32'h00);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_meas", {31'd0, meas_win}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pkt", {16'd0, pkt_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();

    // invert mode, single packet
    kick(2'd3, 16'd1);
    chk("inv_v1", {31'd0, valid}, 32'd1);
    chk("inv_f1", {24'd0, input2, input1}, 32'hFF);
    chk("inv_meas", {31'd0, meas_win}, 32'd1);
    chk("inv_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("inv_f2", {24'd0, input2, input1}, 32'h00);
    tick();
    chk("inv_f3", {24'd0, input2, input1}, 32'hFF);
    tick();
    chk("inv_done", {31'd0, done}, 32'd1);
    chk("inv_done_valid", {31'd0, valid}, 32'd0);
    chk("inv_done_meas", {31'd0, meas_win}, 32'd0);
    chk("inv_pkt", {16'd0, pkt_cnt}, 32'd1);
    chk("inv_hold", {24'd0, input2, input1}, 32'hFF);
    tick();
    chk("inv_done_clr", {31'd0, done}, 32'd0);
    chk("inv_idle_busy", {31'd0, busy}, 32'd0);

    // Johnson mode, two packets with a two-cycle gap
    kick(2'd1, 16'd2);
    chk("jn_p1f1", {24'd0, input2, input1}, 32'h01);
    tick();
    chk("jn_p1f2", {24'd0, input2, input1}, 32'h03);
    tick();
    chk("jn_p1f3", {24'd0, input2, input1}, 32'h07);
    tick();
    chk("jn_gap1_v", {31'd0, valid}, 32'd0);
    chk("jn_gap1_p", {24'd0, input2, input1}, 32'h07);
    chk("jn_gap_pkt", {16'd0, pkt_cnt}, 32'd1);
    chk("jn_gap_meas", {31'd0, meas_win}, 32'd1);
    tick();
    chk("jn_gap2_v", {31'd0, valid}, 32'd0);
    chk("jn_gap2_p", {24'd0, input2, input1}, 32'h07);
    tick();
    chk("jn_p2f1_v", {31'd0, valid}, 32'd1);
    chk("jn_p2f1", {24'd0, input2, input1}, 32'h01);
    tick();
    chk("jn_p2f2", {24'd0, input2, input1}, 32'h03);
    tick();
    chk("jn_p2f3", {24'd0, input2, input1}, 32'h07);
    tick();
    chk("jn_done", {31'd0, done}, 32'd1);
    chk("jn_pkt", {16'd0, pkt_cnt}, 32'd2);
    tick();

    // LFSR mode: 1 -> 8020_0003 -> C030_0002 -> 6018_0001
    kick(2'd2, 16'd2);
    chk("lf_p1f1", {24'd0, input2, input1}, 32'h03);
    tick();
    chk("lf_p1f2", {24'd0, input2, input1}, 32'h02);
    tick();
    chk("lf_p1f3", {24'd0, input2, input1}, 32'h01);
    repeat (3) tick();
    chk("lf_p2f1", {24'd0, input2, input1}, 32'h03);
    repeat (3) tick();
    chk("lf_done", {31'd0, done}, 32'd1);
    tick();

    // backpressure on flit 2
    kick(2'd3, 16'd1);
    chk("bp_f1", {24'd0, input2, input1}, 32'hFF);
    tick();
    chk("bp_f2", {24'd0, input2, input1}, 32'h00);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_v", {31'd0, valid}, 32'd1);
      chk("bp_hold_p", {24'd0, input2, input1}, 32'h00);
    end
    ready = 1'b1;
    tick();
    chk("bp_f3", {24'd0, input2, input1}, 32'hFF);
    tick();
    chk("bp_done", {31'd0, done}, 32'd1);
    chk("bp_pkt", {16'd0, pkt_cnt}, 32'd1);
    tick();

    // GAP=0 twin: two packets back to back
    mode = 2'd3; num_pkt = 16'd2; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic [7:0] e;
      e = (i % 3 == 1) ? 8'h00 : 8'hFF;
      chk("g0_valid", {31'd0, valid0}, 32'd1);
      chk("g0_pat", {24'd0, input2_0, input1_0}, {24'd0, e});
      tick();
    end
    chk("g0_done", {31'd0, done0}, 32'd1);
    chk("g0_pkt", {16'd0, pkt_cnt0}, 32'd2);
    tick();

    // zero packets
    kick(2'd3, 16'd0);
    chk("z_done", {31'd0, done}, 32'd1);
    chk("z_valid", {31'd0, valid}, 32'd0);
    chk("z_meas", {31'd0, meas_win}, 32'd0);
    tick();
    chk("z_done_clr", {31'd0, done}, 32'd0);
    chk("z_valid2", {31'd0, valid}, 32'd0);

    // start together with abort in IDLE
    mode = 2'd3; num_pkt = 16'd1; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", {31'd0, busy}, 32'd0);
    chk("sa_valid", {31'd0, valid}, 32'd0);
    chk("sa_done", {31'd0, done}, 32'd0);

    // abort mid-GAP
    kick(2'd1, 16'd2);
    tick(); tick(); tick();
    chk("ab_ingap", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy", {31'd0, busy}, 32'd0);
    chk("ab_meas", {31'd0, meas_win}, 32'd0);
    chk("ab_done", {31'd0, done}, 32'd0);
    chk("ab_hold", {24'd0, input2, input1}, 32'h07);
    tick();
    chk("ab_done2", {31'd0, done}, 32'd0);

    // asynchronous reset mid-SEND
    kick(2'd3, 16'd1);
    chk("ar_pre", {31'd0, valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, valid}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_meas", {31'd0, meas_win}, 32'd0);
    chk("ar_pat", {24'd0, input2, input1}, 32'h00);
    chk("ar_pkt", {16'd0, pkt_cnt}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_nodone", {31'd0, done}, 32'd0);
    chk("ar_idle", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/char_pattern_gen.md
Name: char_pattern_gen

Overview:
Synthesizable, parametrised stimulus generator for energy characterization of N-bit datapath units (adders and similar two-operand blocks). It drives a 2N-bit pattern onto two operand buses with selectable toggle activity: 0%, minimum (1 bit per flit), about 50% (LFSR) or 100%. Traffic is packetised: PAYLOAD flits per packet, GAP idle cycles between packets, num_pkt packets per run. It replaces fixed hand-written pattern tables and hard-coded link-utilization delays, and supports valid/ready backpressure from the unit under test.

Parameters:
N, 23, operand width; pattern register width is 2N.
PAYLOAD, 20, flits per packet; must be >= 1.
GAP, 7, idle cycles between packets; 0 is legal.
SEED, 32'h0000_0001, LFSR seed; a value of 0 is replaced by 1.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle run request; honoured only in IDLE.
abort  in  1  synchronous run cancel.
mode  in  2  0=zero, 1=Johnson (minimum toggle), 2=LFSR (about 50%), 3=invert (100%); latched on start.
num_pkt  in  16  packets per run; latched on start.
ready  in  1  downstream accepts the current flit.
valid  out  1  input1/input2 hold a flit.
input1  out  N  pattern bits [N-1:0].
input2  out  N  pattern bits [2N-1:N].
busy  out  1  high in SEND or GAP.
meas_win  out  1  measurement window (dump-enable equivalent).
done  out  1  one-cycle pulse at end of run.
pkt_cnt  out  16  packets completed in the current run.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - Pattern register P, valid, busy, meas_win, done, pkt_cnt and all internal counters are cleared to 0.
  - LFSR register L is loaded with SEED.
  - Reset during SEND or GAP takes effect immediately, with no final flit and no done pulse.
- Operand mapping: input1 = P[N-1:0], input2 = P[2N-1:N], always (not gated by valid).
- Step function S(P), by latched mode:
  - mode 0: 0.
  - mode 1: {P[2N-2:0], ~P[2N-1]} (Johnson).
  - mode 2: L steps once as a 32-bit Galois right-shift with mask 32'h8020_0003 (L = L>>1, XOR mask if old L[0]=1). S = the new L replicated to 2N bits, bit i = L[i mod 32].
  - mode 3: ~P.
- FSM states: IDLE, SEND, GAP, DONE.
- IDLE:
  - On start=1: latch mode and num_pkt; clear pkt_cnt.
  - If num_pkt=0, go to DONE.
  - Otherwise enter SEND: set P = S(init) with init = 0 and L = SEED; assert meas_win.
  - Mode and num_pkt changes while not in IDLE are ignored.
- SEND:
  - valid=1.
  - A flit is accepted when valid & ready.
  - While ready=0, P is stable (no step).
  - On accept of flit k < PAYLOAD: P <= S(P).
  - On accept of flit PAYLOAD: pkt_cnt += 1, and P holds its value.
    - If pkt_cnt+1 == num_pkt, go to DONE.
    - Else if GAP > 0, go to GAP.
    - Else re-init P and L as on entry, staying in SEND (back-to-back packets, no bubble).
- GAP:
  - valid=0 and P holds.
  - After exactly GAP cycles, re-init P and L and return to SEND.
- DONE:
  - done=1 for exactly one cycle; meas_win drops in the same cycle; then go to IDLE.
  - P holds its last flit.
- abort=1 in SEND or GAP: go to IDLE next edge, clear valid, busy and meas_win, no done pulse, P holds. Abort takes priority over an accept in the same cycle.
- start while busy: ignored. start and abort both high in IDLE: abort wins and the run does not start.
- busy = (state is SEND or GAP).
- Flit counter width: $clog2(PAYLOAD+1). pkt_cnt saturates at 16'hFFFF.

Test Plan:
- Mode 3 (invert): N=4, PAYLOAD=3, GAP=2, num_pkt=1, ready=1, start -> flits {input2,input1} = 8'hFF, 8'h00, 8'hFF on consecutive cycles; done pulses one cycle after the third accept; pkt_cnt=1.
- Mode 1 (Johnson): same config, num_pkt=2 -> each packet is 8'h01, 8'h03, 8'h07; exactly 2 valid=0 cycles between packets; P holds 8'h07 during the gap.
- Mode 2 (LFSR): SEED=1, N=4 -> first flit is 8'h03 (L=32'h8020_0003); the second packet's first flit is again 8'h03.
- Backpressure: mode 3, ready low for 3 cycles on flit 2 -> 8'h00 held stable with valid=1 throughout; the sequence resumes unchanged.
- Boundary config: GAP=0 with num_pkt=2 -> 6 consecutive valid cycles. num_pkt=0 -> done pulse after 1 cycle, valid never high.
- Reset and abort: rst_n low mid-SEND -> all outputs 0 asynchronously. abort mid-GAP -> IDLE, no done pulse, busy=0 next cycle.
